fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be:
- PAR_FIFO_DW, default 8, data width (>=1).
- PAR_NUM_REQ, default 4, number of requesters (2..8).
- PAR_MAX_PKT, default 16, maximum words per packet (2..256).
- GNT_W = Clog2(PAR_NUM_REQ).
REQ-002 Ports SHALL be:
- i_par_fifo_clk  in  1  clock.
- i_par_fifo_reset_b  in  1  reset, asynchronous, active-low.
- i_par_fifo_clr  in  1  synchronous clear.
- i_req_valid  in  PAR_NUM_REQ  per-requester word valid.
- i_req_data  in  PAR_NUM_REQ*PAR_FIFO_DW  packed words; requester k occupies bits [k*DW +: DW].
- i_req_last  in  PAR_NUM_REQ  last word of packet.
- o_req_ready  out  PAR_NUM_REQ  word accepted when valid&ready.
- o_par_fifo_spush  out  1  FIFO push.
- o_par_fifo_swdata  out  PAR_FIFO_DW  FIFO write data.
- i_par_fifo_sfull  in  1  FIFO full.
- o_grant_id  out  GNT_W  current owner.
- o_busy  out  1  packet in progress.
- o_err_pkt_len  out  1  one-cycle pulse on forced release.

Function
REQ-003 The FSM SHALL have two states: IDLE and XFER.
REQ-004 In IDLE, when any i_req_valid bit is 1, the block SHALL do all of the following at the next edge:
- register o_grant_id = first valid requester at or after rr_ptr, searching upward modulo PAR_NUM_REQ;
- clear word_cnt to 0;
- enter XFER.
REQ-005 Arbitration latency SHALL be one cycle; no word is accepted in IDLE, and o_req_ready SHALL be all-zero in IDLE.
REQ-006 In XFER, o_req_ready[o_grant_id] SHALL equal ~i_par_fifo_sfull; all other ready bits SHALL be 0.
REQ-007 o_par_fifo_spush SHALL equal i_req_valid[o_grant_id] & ~i_par_fifo_sfull & (state==XFER) & ~i_par_fifo_clr, combinationally in the same cycle.
REQ-008 o_par_fifo_swdata SHALL equal the granted requester's data slice whenever in XFER, and SHALL be 0 in IDLE.
REQ-009 Each push SHALL increment word_cnt (width Clog2(PAR_MAX_PKT)+1), which does not wrap within a packet.
REQ-010 A push with i_req_last[o_grant_id]=1 SHALL end the packet: next state IDLE, rr_ptr = o_grant_id+1 modulo PAR_NUM_REQ.
REQ-011 A push without last, when word_cnt==PAR_MAX_PKT-1, SHALL force release:
- next state IDLE;
- rr_ptr advanced as in REQ-010;
- o_err_pkt_len=1 for exactly the following cycle.
REQ-012 The grant SHALL NOT change while in XFER; deassertion of the owner's valid SHALL stall the packet and SHALL NOT release it.
REQ-013 Valid/last from non-granted requesters SHALL be ignored, and no data from them SHALL be pushed.
REQ-014 Because i_par_fifo_sfull gates ready, a push into a full FIFO SHALL never occur.
REQ-015 o_busy SHALL be 1 exactly when state==XFER.
REQ-016 i_par_fifo_clr SHALL have priority over all other inputs:
- next state IDLE, rr_ptr=0, word_cnt=0, o_grant_id=0;
- no push in that cycle;
- o_err_pkt_len low the next cycle.
REQ-017 The one-cycle IDLE gap between packets SHALL always be present, including when the same requester is the only one valid.

Reset
REQ-018 On i_par_fifo_reset_b low, asynchronously, the block SHALL force:
- state IDLE;
- rr_ptr=0, word_cnt=0;
- o_grant_id=0, o_busy=0, o_err_pkt_len=0;
- o_req_ready=0, o_par_fifo_spush=0, o_par_fifo_swdata=0.
REQ-019 Reset asserted mid-packet SHALL abandon the packet with no further push; after release, the first grant SHALL be computed from rr_ptr=0.

Verification
REQ-020 Round robin: defaults, all four valid with 2-word packets -> grants 0,1,2,3,0; 2 pushes per grant; 1-cycle IDLE gap between packets.
REQ-021 Backpressure: sfull held 1 for 3 cycles mid-packet of requester 2 -> ready[2]=0, spush=0 for those 3 cycles; words arrive in order, none duplicated or lost.
REQ-022 Length limit: requester 1 sends 20 words with last never set, PAR_MAX_PKT=16 -> 16 pushes; err pulse 1 cycle; requester 1 then re-arbitrates behind the others.
REQ-023 Stall: owner drops valid for 5 cycles while requester 3 is valid -> grant stays; no push from 3 until the owner sends last.
REQ-024 Clear: clr asserted on a cycle with valid&~sfull in XFER -> no push; IDLE next; next grant goes to the lowest valid index from 0.
REQ-025 Async reset mid-packet: reset_b pulsed low between edges -> outputs zero immediately; no spurious push after release.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter that merges several requesters onto one FIFO write port.
// A grant lasts a whole packet; over-long packets are cut at PAR_MAX_PKT words and flagged.
module fifo_wr_arbiter #(
    parameter  int unsigned PAR_FIFO_DW = 8,
    parameter  int unsigned PAR_NUM_REQ = 4,
    parameter  int unsigned PAR_MAX_PKT = 16,
    localparam int unsigned GNT_W       = $clog2(PAR_NUM_REQ)
) (
    input  logic                               i_par_fifo_clk,
    input  logic                               i_par_fifo_reset_b,
    input  logic                               i_par_fifo_clr,
    input  logic [PAR_NUM_REQ-1:0]             i_req_valid,
    input  logic [PAR_NUM_REQ*PAR_FIFO_DW-1:0] i_req_data,
    input  logic [PAR_NUM_REQ-1:0]             i_req_last,
    output logic [PAR_NUM_REQ-1:0]             o_req_ready,
    output logic                               o_par_fifo_spush,
    output logic [PAR_FIFO_DW-1:0]             o_par_fifo_swdata,
    input  logic                               i_par_fifo_sfull,
    output logic [GNT_W-1:0]                   o_grant_id,
    output logic                               o_busy,
    output logic                               o_err_pkt_len
);

    localparam int unsigned CNT_W = $clog2(PAR_MAX_PKT) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t           state;
    logic [GNT_W-1:0] rr_ptr;
    logic [GNT_W-1:0] arb_id;
    logic [GNT_W-1:0] next_ptr;
    logic [GNT_W:0]   probe;
    logic             found;
    logic [CNT_W-1:0] word_cnt;
    logic             owner_valid;
    logic             owner_last;
    logic             push;

    // First valid requester at or after rr_ptr, wrapping modulo PAR_NUM_REQ.
    always_comb begin
        arb_id = rr_ptr;
        found  = 1'b0;
        probe  = '0;
        for (int unsigned i = 0; i < PAR_NUM_REQ; i++) begin
            probe = {1'b0, rr_ptr} + (GNT_W+1)'(i);
            if (probe >= (GNT_W+1)'(PAR_NUM_REQ)) begin
                probe = probe - (GNT_W+1)'(PAR_NUM_REQ);
            end
            if (!found && i_req_valid[probe[GNT_W-1:0]]) begin
                found  = 1'b1;
                arb_id = probe[GNT_W-1:0];
            end
        end
    end

    assign next_ptr = (o_grant_id == GNT_W'(PAR_NUM_REQ - 1)) ? '0 : o_grant_id + GNT_W'(1);

    // Handshake and write path follow the owner combinationally so a word moves in its own cycle.
    always_comb begin
        owner_valid       = i_req_valid[o_grant_id];
        owner_last        = i_req_last[o_grant_id];
        push              = (state == XFER) && owner_valid && !i_par_fifo_sfull && !i_par_fifo_clr;
        o_req_ready       = '0;
        o_par_fifo_swdata = '0;
        if (state == XFER) begin
            o_req_ready[o_grant_id] = ~i_par_fifo_sfull;
            o_par_fifo_swdata       = i_req_data[32'(o_grant_id) * PAR_FIFO_DW +: PAR_FIFO_DW];
        end
        o_par_fifo_spush  = push;
        o_busy            = (state == XFER);
    end

    always_ff @(posedge i_par_fifo_clk or negedge i_par_fifo_reset_b) begin
        if (!i_par_fifo_reset_b) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            word_cnt      <= '0;
            o_grant_id    <= '0;
            o_err_pkt_len <= 1'b0;
        end else begin
            o_err_pkt_len <= 1'b0;
            if (i_par_fifo_clr) begin
                state      <= IDLE;
                rr_ptr     <= '0;
                word_cnt   <= '0;
                o_grant_id <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (|i_req_valid) begin
                            o_grant_id <= arb_id;
                            word_cnt   <= '0;
                            state      <= XFER;
                        end
                    end
                    XFER: begin
                        if (push) begin
                            word_cnt <= word_cnt + CNT_W'(1);
                            if (owner_last) begin
                                state  <= IDLE;
                                rr_ptr <= next_ptr;
                            end else if (word_cnt == CNT_W'(PAR_MAX_PKT - 1)) begin
                                // Packet hit the length ceiling without a last: cut it off.
                                state         <= IDLE;
                                rr_ptr        <= next_ptr;
                                o_err_pkt_len <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter: per-requester packet sources, an ordered
// expected-word queue, and a negedge monitor capturing every FIFO push.
module tb_fifo_wr_arbiter;

    localparam int DW   = 8;
    localparam int NREQ = 4;

    logic              i_par_fifo_clk = 1'b0;
    logic              i_par_fifo_reset_b;
    logic              i_par_fifo_clr;
    logic [NREQ-1:0]   i_req_valid;
    logic [NREQ*DW-1:0] i_req_data;
    logic [NREQ-1:0]   i_req_last;
    logic [NREQ-1:0]   o_req_ready;
    logic              o_par_fifo_spush;
    logic [DW-1:0]     o_par_fifo_swdata;
    logic              i_par_fifo_sfull;
    logic [1:0]        o_grant_id;
    logic              o_busy;
    logic              o_err_pkt_len;

    fifo_wr_arbiter dut (
        .i_par_fifo_clk     (i_par_fifo_clk),
        .i_par_fifo_reset_b (i_par_fifo_reset_b),
        .i_par_fifo_clr     (i_par_fifo_clr),
        .i_req_valid        (i_req_valid),
        .i_req_data         (i_req_data),
        .i_req_last         (i_req_last),
        .o_req_ready        (o_req_ready),
        .o_par_fifo_spush   (o_par_fifo_spush),
        .o_par_fifo_swdata  (o_par_fifo_swdata),
        .i_par_fifo_sfull   (i_par_fifo_sfull),
        .o_grant_id         (o_grant_id),
        .o_busy             (o_busy),
        .o_err_pkt_len      (o_err_pkt_len)
    );

    always #5 i_par_fifo_clk = ~i_par_fifo_clk;

    int checks   = 0;
    int failures = 0;

    logic [8:0]      src_q [NREQ][$];
    logic [NREQ-1:0] en;
    logic [NREQ-1:0] acc = '0;
    logic [7:0]      exp_q [$];
    logic [8:0]      obs_q [$];
    int              obs_rd;
    int              got_q [$];
    int              pkt_q [$];
    bit              prev_busy;
    int              idle_run;
    int              gap_err;

    // Captures accepted handshakes and every push together with the sfull seen alongside it.
    always @(negedge i_par_fifo_clk) begin
        acc <= i_req_valid & o_req_ready & ~{NREQ{i_par_fifo_clr}};
        if (o_par_fifo_spush) obs_q.push_back({i_par_fifo_sfull, o_par_fifo_swdata});
    end

    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            i_req_valid[k] = en[k] && (src_q[k].size() > 0);
            if (src_q[k].size() > 0) begin
                i_req_data[k*DW +: DW] = src_q[k][0][7:0];
                i_req_last[k]          = src_q[k][0][8];
            end else begin
                i_req_data[k*DW +: DW] = '0;
                i_req_last[k]          = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge i_par_fifo_clk);
        #1;
        for (int k = 0; k < NREQ; k++)
            if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        drive();
        #1;
    endtask

    task automatic add_pkt(input int k, input int base, input int n, input bit has_last);
        for (int i = 0; i < n; i++)
            src_q[k].push_back({has_last && (i == n - 1), 8'(k * 64 + base + i)});
    endtask

    task automatic exp_words(input int k, input int base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'(k * 64 + base + i));
    endtask

    task automatic trk_reset();
        got_q.delete();
        pkt_q.delete();
        prev_busy = 1'b0;
        idle_run  = 1;
        gap_err   = 0;
    endtask

    // Records the grant at each packet start, pushes per packet, and idle gap lengths.
    task automatic track();
        if (o_busy && !prev_busy) begin
            got_q.push_back(int'(o_grant_id));
            if (got_q.size() > 1 && idle_run != 1) gap_err++;
            pkt_q.push_back(0);
        end
        if (o_busy && o_par_fifo_spush && pkt_q.size() > 0)
            pkt_q[pkt_q.size()-1] = pkt_q[pkt_q.size()-1] + 1;
        idle_run  = o_busy ? 0 : idle_run + 1;
        prev_busy = o_busy;
    endtask

    task automatic test_reset();
        i_par_fifo_reset_b = 1'b0;
        i_req_valid = '1;
        i_req_data  = 32'hA5A5_A5A5;
        repeat (2) @(posedge i_par_fifo_clk);
        #2;
        checks++; if (o_grant_id !== 2'd0) begin failures++; $display("FAIL rst_grant got=%0d exp=0", o_grant_id); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", o_busy); end
        checks++; if (o_err_pkt_len !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", o_err_pkt_len); end
        checks++; if (o_req_ready !== 4'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0000", o_req_ready); end
        checks++; if (o_par_fifo_spush !== 1'b0) begin failures++; $display("FAIL rst_spush got=%0b exp=0", o_par_fifo_spush); end
        checks++; if (o_par_fifo_swdata !== 8'h00) begin failures++; $display("FAIL rst_swdata got=%h exp=00", o_par_fifo_swdata); end
        en = '0;
        drive();
        i_par_fifo_reset_b = 1'b1;
        step();
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL post_rst_busy got=%0b exp=0", o_busy); end
    endtask

    task automatic test_round_robin();
        int exp_g [5] = '{0, 1, 2, 3, 0};
        trk_reset();
        add_pkt(0, 0, 2, 1); add_pkt(0, 2, 2, 1);
        add_pkt(1, 0, 2, 1); add_pkt(2, 0, 2, 1); add_pkt(3, 0, 2, 1);
        exp_words(0, 0, 2); exp_words(1, 0, 2); exp_words(2, 0, 2); exp_words(3, 0, 2); exp_words(0, 2, 2);
        en = '1;
        for (int c = 0; c < 30; c++) begin
            drive(); #1;
            track();
            step();
        end
        en = '0; drive();
        checks++; if (got_q.size() != 5) begin failures++; $display("FAIL rr_grants got=%0d exp=5", got_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) begin
                checks++; if (got_q[i] != exp_g[i]) begin failures++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, got_q[i], exp_g[i]); end
                checks++; if (pkt_q[i] != 2) begin failures++; $display("FAIL rr_pkt_len[%0d] got=%0d exp=2", i, pkt_q[i]); end
            end
        end
        checks++; if (gap_err != 0) begin failures++; $display("FAIL rr_idle_gap got=%0d bad gaps exp=0", gap_err); end
        checks++; if (obs_q.size() != obs_rd + exp_q.size()) begin failures++; $display("FAIL rr_push_count got=%0d exp=%0d", obs_q.size() - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            checks++; if (obs_q[obs_rd] !== {1'b0, exp_q[0]}) begin failures++; $display("FAIL rr_word got=%h exp=%h", obs_q[obs_rd], {1'b0, exp_q[0]}); end
            obs_rd++; void'(exp_q.pop_front());
        end
        exp_q.delete(); obs_rd = obs_q.size();
    endtask

    task automatic test_backpressure();
        int stall = 0;
        trk_reset();
        add_pkt(2, 0, 6, 1);
        exp_words(2, 0, 6);
        en = 4'b0100;
        for (int c = 0; c < 30; c++) begin
            i_par_fifo_sfull = (pkt_q.size() > 0 && pkt_q[0] == 2 && stall < 3);
            drive(); #1;
            track();
            if (i_par_fifo_sfull) begin
                stall++;
                checks++; if (o_req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready got=%b exp=0000", o_req_ready); end
                checks++; if (o_par_fifo_spush !== 1'b0) begin failures++; $display("FAIL bp_spush got=%0b exp=0", o_par_fifo_spush); end
                checks++; if (o_grant_id !== 2'd2) begin failures++; $display("FAIL bp_grant got=%0d exp=2", o_grant_id); end
            end
            step();
        end
        i_par_fifo_sfull = 1'b0;
        en = '0; drive();
        checks++; if (stall != 3) begin failures++; $display("FAIL bp_stall_cycles got=%0d exp=3", stall); end
        checks++; if (pkt_q.size() != 1 || pkt_q[0] != 6) begin failures++; $display("FAIL bp_pkt got=%0d pkts exp=1 pkt of 6", pkt_q.size()); end
        checks++; if (obs_q.size() != obs_rd + exp_q.size()) begin failures++; $display("FAIL bp_push_count got=%0d exp=%0d", obs_q.size() - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            checks++; if (obs_q[obs_rd] !== {1'b0, exp_q[0]}) begin failures++; $display("FAIL bp_word got=%h exp=%h", obs_q[obs_rd], {1'b0, exp_q[0]}); end
            obs_rd++; void'(exp_q.pop_front());
        end
        exp_q.delete(); obs_rd = obs_q.size();
    endtask

    task automatic test_length_limit();
        int exp_g [4] = '{1, 3, 0, 1};
        int exp_n [4] = '{16, 2, 2, 4};
        int err_cycles = 0;
        int err_c = -1;
        int p16_c = -1;
        trk_reset();
        add_pkt(1, 0, 20, 0); add_pkt(3, 0, 2, 1); add_pkt(0, 0, 2, 1);
        exp_words(1, 0, 16); exp_words(3, 0, 2); exp_words(0, 0, 2); exp_words(1, 16, 4);
        en = 4'b0010;
        for (int c = 0; c < 50; c++) begin
            if (got_q.size() >= 1) en = 4'b1011;
            drive(); #1;
            track();
            if (o_err_pkt_len) begin err_cycles++; err_c = c; end
            if (p16_c < 0 && pkt_q.size() == 1 && pkt_q[0] == 16) p16_c = c;
            step();
        end
        en = '0; drive();
        checks++; if (err_cycles != 1) begin failures++; $display("FAIL len_err_cycles got=%0d exp=1", err_cycles); end
        checks++; if (err_c != p16_c + 1) begin failures++; $display("FAIL len_err_timing got=%0d exp=%0d", err_c, p16_c + 1); end
        checks++; if (got_q.size() != 4) begin failures++; $display("FAIL len_grants got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) begin
                checks++; if (got_q[i] != exp_g[i]) begin failures++; $display("FAIL len_grant[%0d] got=%0d exp=%0d", i, got_q[i], exp_g[i]); end
                checks++; if (pkt_q[i] != exp_n[i]) begin failures++; $display("FAIL len_pkt[%0d] got=%0d exp=%0d", i, pkt_q[i], exp_n[i]); end
            end
        end
        checks++; if (obs_q.size() != obs_rd + exp_q.size()) begin failures++; $display("FAIL len_push_count got=%0d exp=%0d", obs_q.size() - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            checks++; if (obs_q[obs_rd] !== {1'b0, exp_q[0]}) begin failures++; $display("FAIL len_word got=%h exp=%h", obs_q[obs_rd], {1'b0, exp_q[0]}); end
            obs_rd++; void'(exp_q.pop_front());
        end
        exp_q.delete(); obs_rd = obs_q.size();
        // Requester 1 is left owning an open packet; clear returns the arbiter to idle.
        i_par_fifo_clr = 1'b1;
        step();
        i_par_fifo_clr = 1'b0;
        #1;
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL len_clr_busy got=%0b exp=0", o_busy); end
        checks++; if (o_grant_id !== 2'd0) begin failures++; $display("FAIL len_clr_grant got=%0d exp=0", o_grant_id); end
    endtask

    task automatic test_stall();
        int st = 0;
        trk_reset();
        add_pkt(0, 0, 4, 1); add_pkt(3, 0, 2, 1);
        exp_words(0, 0, 4); exp_words(3, 0, 2);
        en = 4'b1001;
        for (int c = 0; c < 40; c++) begin
            if (pkt_q.size() == 1 && pkt_q[0] == 2 && st < 5) begin en[0] = 1'b0; st++; end
            else en[0] = 1'b1;
            drive(); #1;
            track();
            if (!en[0]) begin
                checks++; if (o_busy !== 1'b1 || o_grant_id !== 2'd0) begin failures++; $display("FAIL stall_owner got=busy%0b/id%0d exp=busy1/id0", o_busy, o_grant_id); end
                checks++; if (o_par_fifo_spush !== 1'b0) begin failures++; $display("FAIL stall_spush got=%0b exp=0", o_par_fifo_spush); end
                checks++; if (o_req_ready !== 4'b0001) begin failures++; $display("FAIL stall_ready got=%b exp=0001", o_req_ready); end
            end
            step();
        end
        en = '0; drive();
        checks++; if (st != 5) begin failures++; $display("FAIL stall_cycles got=%0d exp=5", st); end
        checks++; if (got_q.size() != 2 || got_q[0] != 0 || got_q[1] != 3) begin failures++; $display("FAIL stall_grants got=%0d grants exp=0 then 3", got_q.size()); end
        checks++; if (pkt_q.size() != 2 || pkt_q[0] != 4 || pkt_q[1] != 2) begin failures++; $display("FAIL stall_pkts got=%0d pkts exp=4 then 2", pkt_q.size()); end
        checks++; if (obs_q.size() != obs_rd + exp_q.size()) begin failures++; $display("FAIL stall_push_count got=%0d exp=%0d", obs_q.size() - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            checks++; if (obs_q[obs_rd] !== {1'b0, exp_q[0]}) begin failures++; $display("FAIL stall_word got=%h exp=%h", obs_q[obs_rd], {1'b0, exp_q[0]}); end
            obs_rd++; void'(exp_q.pop_front());
        end
        exp_q.delete(); obs_rd = obs_q.size();
    endtask

    task automatic test_clear();
        int exp_g [5] = '{2, 2, 1, 2, 3};
        int clr_c = -1;
        trk_reset();
        add_pkt(2, 0, 1, 1); add_pkt(2, 1, 4, 1); add_pkt(1, 0, 1, 1); add_pkt(3, 0, 1, 1);
        exp_words(2, 0, 1); exp_words(2, 1, 1); exp_words(1, 0, 1); exp_words(2, 2, 3); exp_words(3, 0, 1);
        en = 4'b0100;
        for (int c = 0; c < 40; c++) begin
            if (clr_c < 0 && pkt_q.size() == 2 && pkt_q[1] == 1) begin
                i_par_fifo_clr = 1'b1; en = 4'b1110; clr_c = c;
            end else i_par_fifo_clr = 1'b0;
            drive(); #1;
            track();
            if (c == clr_c) begin
                checks++; if (i_req_valid[2] !== 1'b1 || o_par_fifo_spush !== 1'b0) begin failures++; $display("FAIL clr_spush got=%0b exp=0 (valid=%0b)", o_par_fifo_spush, i_req_valid[2]); end
            end
            if (clr_c >= 0 && c == clr_c + 1) begin
                checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL clr_busy got=%0b exp=0", o_busy); end
                checks++; if (o_grant_id !== 2'd0) begin failures++; $display("FAIL clr_grant got=%0d exp=0", o_grant_id); end
                checks++; if (o_err_pkt_len !== 1'b0) begin failures++; $display("FAIL clr_err got=%0b exp=0", o_err_pkt_len); end
            end
            step();
        end
        i_par_fifo_clr = 1'b0;
        en = '0; drive();
        checks++; if (got_q.size() != 5) begin failures++; $display("FAIL clr_grants got=%0d exp=5", got_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) begin
                checks++; if (got_q[i] != exp_g[i]) begin failures++; $display("FAIL clr_grant[%0d] got=%0d exp=%0d", i, got_q[i], exp_g[i]); end
            end
        end
        checks++; if (obs_q.size() != obs_rd + exp_q.size()) begin failures++; $display("FAIL clr_push_count got=%0d exp=%0d", obs_q.size() - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            checks++; if (obs_q[obs_rd] !== {1'b0, exp_q[0]}) begin failures++; $display("FAIL clr_word got=%h exp=%h", obs_q[obs_rd], {1'b0, exp_q[0]}); end
            obs_rd++; void'(exp_q.pop_front());
        end
        exp_q.delete(); obs_rd = obs_q.size();
    endtask

    task automatic test_async_reset();
        int exp_g [5] = '{2, 1, 0, 1, 3};
        int exp_n [5] = '{1, 2, 1, 4, 1};
        bit rst_done = 1'b0;
        trk_reset();
        add_pkt(2, 0, 1, 1); add_pkt(1, 0, 6, 1); add_pkt(0, 0, 1, 1); add_pkt(3, 0, 1, 1);
        exp_words(2, 0, 1); exp_words(1, 0, 2); exp_words(0, 0, 1); exp_words(1, 2, 4); exp_words(3, 0, 1);
        en = 4'b0100;
        for (int c = 0; c < 40; c++) begin
            if (!rst_done && got_q.size() >= 1) en = 4'b0110;
            if (!rst_done && got_q.size() == 2 && pkt_q[1] == 2) begin
                en = 4'b1011;
                drive();
                i_par_fifo_reset_b = 1'b0;
                #1;
                checks++; if (o_req_ready !== 4'b0000) begin failures++; $display("FAIL arst_ready got=%b exp=0000", o_req_ready); end
                checks++; if (o_par_fifo_spush !== 1'b0) begin failures++; $display("FAIL arst_spush got=%0b exp=0", o_par_fifo_spush); end
                checks++; if (o_par_fifo_swdata !== 8'h00) begin failures++; $display("FAIL arst_swdata got=%h exp=00", o_par_fifo_swdata); end
                checks++; if (o_busy !== 1'b0 || o_grant_id !== 2'd0 || o_err_pkt_len !== 1'b0) begin failures++; $display("FAIL arst_state got=busy%0b/id%0d/err%0b exp=0/0/0", o_busy, o_grant_id, o_err_pkt_len); end
                #4;
                i_par_fifo_reset_b = 1'b1;
                rst_done = 1'b1;
            end
            drive(); #1;
            track();
            step();
        end
        en = '0; drive();
        checks++; if (got_q.size() != 5) begin failures++; $display("FAIL arst_grants got=%0d exp=5", got_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) begin
                checks++; if (got_q[i] != exp_g[i]) begin failures++; $display("FAIL arst_grant[%0d] got=%0d exp=%0d", i, got_q[i], exp_g[i]); end
                checks++; if (pkt_q[i] != exp_n[i]) begin failures++; $display("FAIL arst_pkt[%0d] got=%0d exp=%0d", i, pkt_q[i], exp_n[i]); end
            end
        end
        checks++; if (obs_q.size() != obs_rd + exp_q.size()) begin failures++; $display("FAIL arst_push_count got=%0d exp=%0d", obs_q.size() - obs_rd, exp_q.size()); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            checks++; if (obs_q[obs_rd] !== {1'b0, exp_q[0]}) begin failures++; $display("FAIL arst_word got=%h exp=%h", obs_q[obs_rd], {1'b0, exp_q[0]}); end
            obs_rd++; void'(exp_q.pop_front());
        end
        exp_q.delete(); obs_rd = obs_q.size();
    endtask

    initial begin
        i_par_fifo_reset_b = 1'b0;
        i_par_fifo_clr     = 1'b0;
        i_par_fifo_sfull   = 1'b0;
        i_req_valid        = '0;
        i_req_data         = '0;
        i_req_last         = '0;
        en                 = '0;
        obs_rd             = 0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_length_limit();
        test_stall();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
